// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus of if_fetch_ctrl: ROM address/data, hazard and redirect inputs,
// and the IF/ID pipeline latch outputs. master = fetch controller, slave = environment.
interface if_fetch_ctrl_if;
   logic [31:0] rom_a;
   logic [31:0] rom_inst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic        fetch_fault;

   modport master (
      output rom_a, id_inst, id_pc, id_pc4, id_valid, fetch_fault,
      input  rom_inst, stall, redirect, redirect_pc
   );

   modport slave (
      input  rom_a, id_inst, id_pc, id_pc4, id_valid, fetch_fault,
      output rom_inst, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC register, ROM addressing, IF/ID latch, stall/redirect/fault.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          ROM_DEPTH = 64,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   if_fetch_ctrl_if.master bus
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetch,
   output logic [31:0]     perf_stall,
   output logic [31:0]     perf_flush
`endif
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [29:0] ROM_LIMIT = ROM_DEPTH[29:0];

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] id_inst_q, id_pc_q, id_pc4_q;
   logic        id_valid_q;
   logic        do_fetch, do_bubble, stall_hold;
   logic [31:0] target;

   assign target = bus.redirect_pc & 32'hFFFF_FFFC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Redirect always wins; stall only matters in RUN; FAULT parks until redirected.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      do_fetch   = 1'b0;
      do_bubble  = 1'b0;
      stall_hold = 1'b0;
      case (state)
         BOOT: begin
            do_bubble  = 1'b1;
            state_next = RUN;
            if (bus.redirect) pc_next = target;
         end
         RUN: begin
            if (bus.redirect) begin
               pc_next   = target;
               do_bubble = 1'b1;
            end else if (bus.stall) begin
               stall_hold = 1'b1;
            end else if (pc[31:2] >= ROM_LIMIT) begin
               state_next = FAULT;
               do_bubble  = 1'b1;
            end else begin
               do_fetch = 1'b1;
               pc_next  = pc + 32'd4;
            end
         end
         FAULT: begin
            do_bubble = 1'b1;
            if (bus.redirect) begin
               pc_next    = target;
               state_next = RUN;
            end
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   // A bubble only rewrites id_inst/id_valid; id_pc and id_pc4 keep their last values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         id_inst_q  <= NOP_WORD;
         id_pc_q    <= 32'd0;
         id_pc4_q   <= 32'd4;
         id_valid_q <= 1'b0;
      end else begin
         pc <= pc_next;
         if (do_fetch) begin
            id_inst_q  <= bus.rom_inst;
            id_pc_q    <= pc;
            id_pc4_q   <= pc + 32'd4;
            id_valid_q <= 1'b1;
         end else if (do_bubble) begin
            id_inst_q  <= NOP_WORD;
            id_valid_q <= 1'b0;
         end
      end
   end

   assign bus.rom_a       = pc;
   assign bus.id_inst     = id_inst_q;
   assign bus.id_pc       = id_pc_q;
   assign bus.id_pc4      = id_pc4_q;
   assign bus.id_valid    = id_valid_q;
   assign bus.fetch_fault = (state == FAULT);

`ifdef IF_PERF_CNT_EN
   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch <= 32'd0;
         perf_stall <= 32'd0;
         perf_flush <= 32'd0;
      end else begin
         if (do_fetch && (perf_fetch != 32'hFFFF_FFFF)) perf_fetch <= perf_fetch + 32'd1;
         if (stall_hold && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
         if (bus.redirect && (perf_flush != 32'hFFFF_FFFF)) perf_flush <= perf_flush + 32'd1;
      end
   end
`else
   logic unused_stall_hold;
   assign unused_stall_hold = stall_hold;
`endif

endmodule
